// File: rtl/output_bridge_multi_port.sv
// Drain stage: one FIFO per core output channel, NUM_PORTS registered read ports with
// same-channel arbitration. Optional macro OB_ROUND_ROBIN_EN selects round-robin arbitration.
module output_bridge_multi_port #(
    parameter int unsigned NUM_CH    = 20,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned WORD_W    = 33,
    parameter int unsigned META_W    = 1,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SEL_W     = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              conf_en,
    input  logic [NUM_CH*(WORD_W+META_W)-1:0] d_in,
    output logic [NUM_CH-1:0]                 c_out,
    input  logic [NUM_PORTS*SEL_W-1:0]        port_sel,
    input  logic [NUM_PORTS-1:0]              rd_en,
    output logic [NUM_PORTS*WORD_W-1:0]       d_out,
    output logic [NUM_PORTS-1:0]              d_valid,
    output logic [NUM_PORTS-1:0]              conflict,
    output logic [NUM_CH-1:0]                 ovf
);
    localparam int unsigned EW = WORD_W + META_W;
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WORD_W-1:0]          mem [NUM_CH][DEPTH];
    logic [AW:0]                wr_ptr_q [NUM_CH];
    logic [AW:0]                rd_ptr_q [NUM_CH];
    logic [WORD_W-1:0]          head [NUM_CH];
    logic [NUM_CH-1:0]          empty, full, push, deq, ovf_d;
    logic [NUM_CH-1:0]          c_out_q, ovf_q;
    int unsigned                sel [NUM_PORTS];
    int unsigned                prio [NUM_PORTS];
    logic [WORD_W-1:0]          rd_word [NUM_PORTS];
    logic [NUM_PORTS-1:0]       req, grant, contested;
    logic [NUM_PORTS*WORD_W-1:0] d_out_q;
    logic [NUM_PORTS-1:0]       d_valid_q, conflict_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                       (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            head[i]  = mem[i][rd_ptr_q[i][AW-1:0]];
        end
    end

    // A request only counts for an in-range, non-empty channel; the loop doubles as the mux.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            sel[p]     = 32'(port_sel[p*SEL_W +: SEL_W]);
            req[p]     = 1'b0;
            rd_word[p] = '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (sel[p] == i) begin
                    req[p]     = rd_en[p] && !empty[i];
                    rd_word[p] = head[i];
                end
            end
        end
    end

`ifdef OB_ROUND_ROBIN_EN
    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    logic [PW-1:0] rr_q, rr_d;
    logic          rr_found;
    int unsigned   rr_idx;

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            prio[p] = (p + NUM_PORTS - 32'(rr_q)) % NUM_PORTS;
        end
    end

    // Move past the first contested winner in rotation order; hold on uncontested cycles.
    always_comb begin
        rr_d     = rr_q;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            rr_idx = (32'(rr_q) + k) % NUM_PORTS;
            if (!rr_found && grant[rr_idx] && contested[rr_idx]) begin
                rr_found = 1'b1;
                rr_d     = PW'((rr_idx + 1) % NUM_PORTS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            prio[p] = p;
        end
    end
`endif

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            grant[p]     = req[p];
            contested[p] = 1'b0;
            for (int unsigned q = 0; q < NUM_PORTS; q++) begin
                if (q != p && req[q] && sel[q] == sel[p]) begin
                    contested[p] = req[p];
                    if (prio[q] < prio[p]) grant[p] = 1'b0;
                end
            end
        end
    end

    // A full FIFO still accepts a word when the same cycle frees its head entry.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            deq[i] = 1'b0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (grant[p] && sel[p] == i) deq[i] = 1'b1;
            end
            push[i]  = d_in[i*EW] && !conf_en && (!full[i] || deq[i]);
            ovf_d[i] = ovf_q[i] | (d_in[i*EW] && !conf_en && full[i] && !deq[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            c_out_q    <= '0;
            ovf_q      <= '0;
            d_out_q    <= '0;
            d_valid_q  <= '0;
            conflict_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + (AW+1)'(1);
                if (deq[i])  rd_ptr_q[i] <= rd_ptr_q[i] + (AW+1)'(1);
            end
            c_out_q    <= deq;
            ovf_q      <= ovf_d;
            d_valid_q  <= grant;
            conflict_q <= req & ~grant;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (grant[p]) d_out_q[p*WORD_W +: WORD_W] <= rd_word[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem[i][wr_ptr_q[i][AW-1:0]] <= d_in[i*EW+META_W +: WORD_W];
        end
    end

    assign c_out    = c_out_q;
    assign ovf      = ovf_q;
    assign d_out    = d_out_q;
    assign d_valid  = d_valid_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_output_bridge_multi_port.sv
// Bench for output_bridge_multi_port: directed scenarios plus random traffic against a
// queue-based reference model. Honours OB_ROUND_ROBIN_EN for the arbitration model.
module tb_output_bridge_multi_port;
    localparam int NUM_CH    = 20;
    localparam int NUM_PORTS = 2;
    localparam int WORD_W    = 33;
    localparam int META_W    = 1;
    localparam int DEPTH     = 4;
    localparam int SEL_W     = 5;
    localparam int EW        = WORD_W + META_W;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic                           conf_en = 1'b0;
    logic [NUM_CH*EW-1:0]           d_in = '0;
    logic [NUM_CH-1:0]              c_out;
    logic [NUM_PORTS*SEL_W-1:0]     port_sel = '0;
    logic [NUM_PORTS-1:0]           rd_en = '0;
    logic [NUM_PORTS*WORD_W-1:0]    d_out;
    logic [NUM_PORTS-1:0]           d_valid;
    logic [NUM_PORTS-1:0]           conflict;
    logic [NUM_CH-1:0]              ovf;

    output_bridge_multi_port #(
        .NUM_CH(NUM_CH), .NUM_PORTS(NUM_PORTS), .WORD_W(WORD_W),
        .META_W(META_W), .DEPTH(DEPTH), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst(rst), .conf_en(conf_en), .d_in(d_in), .c_out(c_out),
        .port_sel(port_sel), .rd_en(rd_en), .d_out(d_out), .d_valid(d_valid),
        .conflict(conflict), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one queue per channel plus expected registered outputs.
    logic [WORD_W-1:0]    fifo [NUM_CH][$];
    logic [WORD_W-1:0]    m_dout [NUM_PORTS];
    logic [NUM_PORTS-1:0] m_dv, m_conf;
    logic [NUM_CH-1:0]    m_c, m_ovf;
    int                   m_rr;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) fifo[i].delete();
        for (int p = 0; p < NUM_PORTS; p++) m_dout[p] = '0;
        m_dv = '0; m_conf = '0; m_c = '0; m_ovf = '0; m_rr = 0;
    endtask

    task automatic model_cycle();
        int served [NUM_CH];
        int nreq [NUM_CH];
        int s, p, new_rr;
        bit seen;
        if (!rst) begin
            model_reset();
            return;
        end
        m_dv = '0; m_conf = '0; m_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin served[i] = -1; nreq[i] = 0; end
        for (int q = 0; q < NUM_PORTS; q++) begin
            s = int'(port_sel[q*SEL_W +: SEL_W]);
            if (rd_en[q] && s < NUM_CH && fifo[s].size() > 0) nreq[s]++;
        end
        new_rr = m_rr;
        seen = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            p = (m_rr + k) % NUM_PORTS;
            s = int'(port_sel[p*SEL_W +: SEL_W]);
            if (rd_en[p] && s < NUM_CH && fifo[s].size() > 0) begin
                if (served[s] < 0) begin
                    served[s] = p;
                    m_dout[p] = fifo[s][0];
                    m_dv[p] = 1'b1;
                    if (nreq[s] > 1 && !seen) begin
                        seen = 1'b1;
                        new_rr = (p + 1) % NUM_PORTS;
                    end
                end else begin
                    m_conf[p] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (served[i] >= 0) begin
                void'(fifo[i].pop_front());
                m_c[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (d_in[i*EW] && !conf_en) begin
                if (fifo[i].size() < DEPTH) fifo[i].push_back(d_in[i*EW+META_W +: WORD_W]);
                else m_ovf[i] = 1'b1;
            end
        end
`ifdef OB_ROUND_ROBIN_EN
        m_rr = new_rr;
`endif
    endtask

    task automatic compare_all(input string tag);
        for (int p = 0; p < NUM_PORTS; p++) begin
            check_eq($sformatf("%s d_out%0d", tag, p), 64'(d_out[p*WORD_W +: WORD_W]),
                     64'(m_dout[p]));
            check_eq($sformatf("%s d_valid%0d", tag, p), 64'(d_valid[p]), 64'(m_dv[p]));
            check_eq($sformatf("%s conflict%0d", tag, p), 64'(conflict[p]), 64'(m_conf[p]));
        end
        check_eq({tag, " c_out"}, 64'(c_out), 64'(m_c));
        check_eq({tag, " ovf"}, 64'(ovf), 64'(m_ovf));
    endtask

    task automatic step(input string tag);
        model_cycle();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic push_word(input int ch, input logic [WORD_W-1:0] w);
        d_in[ch*EW +: EW] = {w, 1'b1};
    endtask

    task automatic set_rd(input int p, input logic en, input int s);
        logic [31:0] sv;
        sv = 32'(s);
        port_sel[p*SEL_W +: SEL_W] = sv[SEL_W-1:0];
        rd_en[p] = en;
    endtask

    task automatic idle();
        d_in = '0;
        rd_en = '0;
        conf_en = 1'b0;
    endtask

    logic [WORD_W-1:0] rw;

    initial begin
        model_reset();
        // T1: reset asserted while words are presented
        #1 rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) push_word(i, WORD_W'(i + 'h100));
        #2;
        check_eq("rst c_out", 64'(c_out), 64'd0);
        check_eq("rst ovf", 64'(ovf), 64'd0);
        check_eq("rst d_valid", 64'(d_valid), 64'd0);
        check_eq("rst conflict", 64'(conflict), 64'd0);
        check_eq("rst d_out", 64'(d_out[WORD_W-1:0]), 64'd0);
        for (int c = 0; c < 3; c++) step("t1_hold");
        idle();
        rst = 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            set_rd(0, 1'b1, ch);
            step("t1_empty");
        end
        idle();

        // T2: two words through ch3
        push_word(3, 'hA5); step("t2_push");
        push_word(3, 'hA6); step("t2_push");
        idle();
        set_rd(0, 1'b1, 3); step("t2_rd");
        check_eq("t2 first word", 64'(d_out[WORD_W-1:0]), 64'hA5);
        check_eq("t2 credit1", 64'(c_out[3]), 64'd1);
        step("t2_rd");
        check_eq("t2 second word", 64'(d_out[WORD_W-1:0]), 64'hA6);
        check_eq("t2 credit2", 64'(c_out[3]), 64'd1);
        idle(); step("t2_idle");

        // T3: fill ch7, overflow, then full with simultaneous read and push
        for (int k = 0; k < DEPTH; k++) begin
            push_word(7, WORD_W'('h70 + k)); step("t3_fill");
        end
        push_word(7, 'h7F); step("t3_ovf");
        check_eq("t3 ovf7 set", 64'(ovf[7]), 64'd1);
        idle();
        push_word(7, 'h77); set_rd(0, 1'b1, 7); step("t3_full_rw");
        idle(); set_rd(0, 1'b1, 7);
        for (int k = 0; k < DEPTH + 1; k++) step("t3_drain");
        check_eq("t3 ovf7 sticky", 64'(ovf[7]), 64'd1);
        idle(); step("t3_idle");

        // T4/T5: both ports contend for ch5
        push_word(5, 'h51); step("t4_push");
        push_word(5, 'h52); step("t4_push");
        idle();
        set_rd(0, 1'b1, 5); set_rd(1, 1'b1, 5);
        step("t4_conf");
        step("t4_conf");
        idle(); step("t4_idle");

        // T6: config phase blocks enqueue; out-of-range select; parallel reads
        conf_en = 1'b1; push_word(0, 'h0C); step("t6_conf");
        idle(); set_rd(0, 1'b1, 0); set_rd(1, 1'b1, 25); step("t6_ignore");
        check_eq("t6 no word ch0", 64'(d_valid), 64'd0);
        idle(); push_word(2, 'h22); push_word(4, 'h44); step("t6_push");
        idle(); set_rd(0, 1'b1, 2); set_rd(1, 1'b1, 4); step("t6_par");
        check_eq("t6 both valid", 64'(d_valid), 64'd3);
        idle(); step("t6_idle");

        // Random traffic with occasional config phases and mid-run resets
        for (int c = 0; c < 800; c++) begin
            idle();
            rst = ($urandom_range(0, 199) != 0);
            conf_en = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, (i < 5) ? 2 : 7) == 0) begin
                    rw = WORD_W'({$urandom(), $urandom()});
                    push_word(i, rw);
                end
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                set_rd(p, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 99) < 85) ? $urandom_range(0, 4) : $urandom_range(0, 31));
            end
            step("rand");
        end
        rst = 1'b1;
        idle();
        step("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
